// File: rtl/pwm_channel_dt.sv
// PWM channel: carrier select, shadowed compare/config, complementary dead-time FSM.
// Optional trip input/latch is built when PWM_TRIP_EN is defined.
module pwm_channel_dt #(
  parameter int CNT_WIDTH = 16,
  parameter int DT_WIDTH  = 8,
  parameter int NCARR     = 8,
  parameter int SEL_WIDTH = $clog2(NCARR)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCARR*CNT_WIDTH-1:0] carriers,
  input  logic [CNT_WIDTH-1:0]       compare,
  input  logic [SEL_WIDTH-1:0]       carrsel,
  input  logic [DT_WIDTH-1:0]        dtime_A,
  input  logic [DT_WIDTH-1:0]        dtime_B,
  input  logic                       logic_A,
  input  logic                       logic_B,
  input  logic                       pwm_onoff,
  input  logic                       maskevent,
`ifdef PWM_TRIP_EN
  input  logic                       trip_in,
  input  logic                       trip_clr,
  output logic                       tripped,
`endif
  output logic                       pwmout_A,
  output logic                       pwmout_B,
  output logic [SEL_WIDTH-1:0]       carrsel_out
);

  // state   | meaning
  // S_OFF   | channel disabled, both outputs inactive
  // S_A_ON  | A active
  // S_DT_BA | dead band from B towards A, both inactive
  // S_B_ON  | B active
  // S_DT_AB | dead band from A towards B, both inactive
  typedef enum logic [2:0] {S_OFF, S_A_ON, S_DT_BA, S_B_ON, S_DT_AB} state_t;

  state_t               r_state, w_state_nxt;
  logic [DT_WIDTH-1:0]  r_dcnt, w_dcnt_nxt;
  logic [CNT_WIDTH-1:0] r_compare;
  logic [SEL_WIDTH-1:0] r_carrsel;
  logic [DT_WIDTH-1:0]  r_dtime_a, r_dtime_b;
  logic                 r_logic_a, r_logic_b;
  logic                 r_raw;
  logic                 r_out_a, r_out_b;
  logic                 w_load, w_hold;
  logic                 w_logic_a_nxt, w_logic_b_nxt;
  logic                 w_out_a, w_out_b;
  logic [CNT_WIDTH-1:0] w_carrier;

  assign w_load = ~pwm_onoff | maskevent;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_compare <= '0;
      r_carrsel <= '0;
      r_dtime_a <= '0;
      r_dtime_b <= '0;
      r_logic_a <= 1'b0;
      r_logic_b <= 1'b0;
    end else if (w_load) begin
      r_compare <= compare;
      r_carrsel <= carrsel;
      r_dtime_a <= dtime_A;
      r_dtime_b <= dtime_B;
      r_logic_a <= logic_A;
      r_logic_b <= logic_B;
    end
  end

  // Out-of-range selects fall back to carrier 0.
  always_comb begin
    w_carrier = carriers[0 +: CNT_WIDTH];
    for (int k = 1; k < NCARR; k++) begin
      if (r_carrsel == SEL_WIDTH'(k)) w_carrier = carriers[k*CNT_WIDTH +: CNT_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_raw <= 1'b0;
    else       r_raw <= pwm_onoff & (w_carrier < r_compare);
  end

`ifdef PWM_TRIP_EN
  logic r_tripped;
  always_ff @(posedge clk) begin
    if (reset)         r_tripped <= 1'b0;
    else if (trip_in)  r_tripped <= 1'b1;
    else if (trip_clr) r_tripped <= 1'b0;
  end
  assign tripped = r_tripped;
  assign w_hold  = ~pwm_onoff | trip_in | r_tripped;
`else
  assign w_hold  = ~pwm_onoff;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_OFF;
      r_dcnt  <= '0;
      r_out_a <= 1'b0;
      r_out_b <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_out_a <= w_out_a;
      r_out_b <= w_out_b;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    if (w_hold) begin
      w_state_nxt = S_OFF;
      w_dcnt_nxt  = '0;
    end else begin
      unique case (r_state)
        S_OFF: w_state_nxt = r_raw ? S_A_ON : S_B_ON;
        S_B_ON: begin
          if (r_raw) begin
            if (r_dtime_a == '0) begin
              w_state_nxt = S_A_ON;
            end else begin
              w_state_nxt = S_DT_BA;
              w_dcnt_nxt  = r_dtime_a - DT_WIDTH'(1);
            end
          end
        end
        S_DT_BA: begin
          if (!r_raw)               w_state_nxt = S_B_ON;
          else if (r_dcnt == '0)    w_state_nxt = S_A_ON;
          else                      w_dcnt_nxt  = r_dcnt - DT_WIDTH'(1);
        end
        S_A_ON: begin
          if (!r_raw) begin
            if (r_dtime_b == '0) begin
              w_state_nxt = S_B_ON;
            end else begin
              w_state_nxt = S_DT_AB;
              w_dcnt_nxt  = r_dtime_b - DT_WIDTH'(1);
            end
          end
        end
        S_DT_AB: begin
          if (r_raw)                w_state_nxt = S_A_ON;
          else if (r_dcnt == '0)    w_state_nxt = S_B_ON;
          else                      w_dcnt_nxt  = r_dcnt - DT_WIDTH'(1);
        end
        default: w_state_nxt = S_OFF;
      endcase
    end
  end

  // Outputs are registered alongside the state, so use the polarity the shadow will hold then.
  assign w_logic_a_nxt = w_load ? logic_A : r_logic_a;
  assign w_logic_b_nxt = w_load ? logic_B : r_logic_b;

  always_comb begin
    w_out_a = (w_state_nxt == S_A_ON) ^ w_logic_a_nxt;
    w_out_b = (w_state_nxt == S_B_ON) ^ w_logic_b_nxt;
  end

  assign pwmout_A    = r_out_a;
  assign pwmout_B    = r_out_b;
  assign carrsel_out = r_carrsel;

endmodule
